// File: rtl/key_pkg.sv
// Shared definitions for the key waveform generator and its debounce partner.
package key_pkg;

  // FSM state encoding (legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Released key reads high
  localparam logic KEY_IDLE_LEVEL = 1'b1;

  // 20 ms at 50 MHz; also the debounce filter's stable threshold
  localparam int KEY_HOLD_20MS = 1000000;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One Galois step: shift right, fold the tap mask in when a 1 falls out
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    lfsr16_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/key_lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, so a stimulus
// sequence depends on the seed and the order of requests, not on time.
module key_lfsr16
  import key_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Adv,
  output logic [15:0] q
);

  logic [15:0] state_q;

  // Reseed on reset, advance one step per Adv
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SEED;
    end else if (Adv) begin
      state_q <= lfsr16_next(state_q);
    end
  end

  assign q = state_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key waveform generator: turns press/release commands into a
// line that bounces a pseudo-random number of times, then holds steady.
//
//   state  | meaning
//   IDLE   | ready for a command, Key steady
//   BOUNCE | bounce edges remain; seg_cnt times the gap to the next edge
//   SETTLE | Key at target, hold_cnt counts the stable period
//   DONE   | single cycle carrying Done_Pulse
module key_bounce_gen
  import key_pkg::*;
#(
  parameter int          BOUNCE_CNT  = 4,
  parameter int          SEG_W       = 4,
  parameter int          HOLD_CYCLES = KEY_HOLD_20MS,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Cmd_Valid,
  input  logic Cmd_Press,
  output logic Cmd_Ready,
  output logic Key,
  output logic Busy,
  output logic Done_Pulse
);

  // Degenerate parameters (no bounce, one-cycle hold) still need 1-bit counters
  localparam int EDGE_W = (BOUNCE_CNT > 0) ? $clog2(2 * BOUNCE_CNT + 1) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SEGC_W = SEG_W + 1;

  localparam logic [EDGE_W-1:0] EDGES_INIT = EDGE_W'(2 * BOUNCE_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        state;
  logic              key_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [SEGC_W-1:0] seg_cnt;
  logic [EDGE_W-1:0] edges_left;
  logic [HOLD_W-1:0] hold_cnt;

  logic [15:0]       lfsr_q;
  logic              lfsr_adv;
  logic [SEGC_W-1:0] seg_load;
  logic              accept;
  logic              target;
  logic              need_edge;
  logic              seg_hit;
  logic              lfsr_unused;

  key_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .Adv   (lfsr_adv),
    .q     (lfsr_q)
  );

  // Only the low SEG_W bits shape the segment length
  assign lfsr_unused = ^(lfsr_q >> SEG_W);

  // Handshake, target level and edge timing decode
  always_comb begin
    accept    = Cmd_Valid && ready_q;
    target    = ~Cmd_Press;
    need_edge = accept && (target != key_q);
    seg_hit   = (state == ST_BOUNCE) && (seg_cnt == SEGC_W'(1));
    seg_load  = SEGC_W'(lfsr_q[SEG_W-1:0]) + SEGC_W'(1);
    // The LFSR steps exactly when a segment length is loaded
    lfsr_adv  = need_edge || seg_hit;
  end

  // Command FSM with segment, edge and hold counters and the Key register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      key_q      <= KEY_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_cnt    <= '0;
      edges_left <= '0;
      hold_cnt   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (need_edge) begin
              key_q      <= ~key_q;
              edges_left <= EDGES_INIT;
              seg_cnt    <= seg_load;
              hold_cnt   <= '0;
              state      <= (BOUNCE_CNT == 0) ? ST_SETTLE : ST_BOUNCE;
            end else begin
              // Already at the requested level: report completion only
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end

        ST_BOUNCE: begin
          if (seg_hit) begin
            key_q      <= ~key_q;
            edges_left <= edges_left - EDGE_W'(1);
            seg_cnt    <= seg_load;
            if (edges_left == EDGE_W'(1)) begin
              // Odd total edge count leaves Key at the target here
              state    <= ST_SETTLE;
              hold_cnt <= '0;
            end
          end else begin
            seg_cnt <= seg_cnt - SEGC_W'(1);
          end
        end

        ST_SETTLE: begin
          if (hold_cnt == HOLD_LAST) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Cmd_Ready  = ready_q;
  assign Key        = key_q;
  assign Busy       = busy_q;
  assign Done_Pulse = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen: a clean-edge instance (no bounce,
// 10-cycle hold) and a bouncing instance (3 pairs, 20-cycle hold).
module tb_key_bounce_gen;

  logic Clk = 1'b0;
  logic Reset;

  logic v0, p0, r0, k0, b0, d0;
  logic v3, p3, r3, k3, b3, d3;

  int n_vec = 0;
  int n_err = 0;

  // Edge cycles (relative to acceptance) for seed ACE1, 4-bit segments:
  // gaps 2,1,9,13,15,8
  int exp_edge [7] = '{1, 3, 4, 13, 26, 41, 49};

  always #5 Clk = ~Clk;

  key_bounce_gen #(
    .BOUNCE_CNT  (0),
    .SEG_W       (4),
    .HOLD_CYCLES (10),
    .LFSR_SEED   (16'hACE1)
  ) dut0 (
    .Clk        (Clk),
    .Reset      (Reset),
    .Cmd_Valid  (v0),
    .Cmd_Press  (p0),
    .Cmd_Ready  (r0),
    .Key        (k0),
    .Busy       (b0),
    .Done_Pulse (d0)
  );

  key_bounce_gen #(
    .BOUNCE_CNT  (3),
    .SEG_W       (4),
    .HOLD_CYCLES (20),
    .LFSR_SEED   (16'hACE1)
  ) dut3 (
    .Clk        (Clk),
    .Reset      (Reset),
    .Cmd_Valid  (v3),
    .Cmd_Press  (p3),
    .Cmd_Ready  (r3),
    .Key        (k3),
    .Busy       (b3),
    .Done_Pulse (d3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Press on the bouncing instance from Key=1 and check the whole waveform
  task automatic run_press3(input string tag);
    int   n_edges;
    int   n_done;
    int   done_at;
    logic prev;
    n_edges = 0;
    n_done  = 0;
    done_at = -1;
    prev    = k3;
    v3 = 1'b1; p3 = 1'b1;
    tick;
    v3 = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      if (c > 1) tick;
      if (k3 !== prev) begin
        if (n_edges < 7) chk({tag, " edge time"}, c, exp_edge[n_edges]);
        else             chk({tag, " extra edge"}, c, 0);
        n_edges++;
        prev = k3;
      end
      if (d3 === 1'b1) begin
        n_done++;
        done_at = c;
      end
      if (c == 1)  chk({tag, " busy after accept"}, b3, 1);
      if (c == 69) chk({tag, " ready during done"}, r3, 0);
      if (c == 70) begin
        chk({tag, " ready after done"}, r3, 1);
        chk({tag, " busy after done"}, b3, 0);
      end
    end
    chk({tag, " edge count"}, n_edges, 7);
    chk({tag, " done count"}, n_done, 1);
    chk({tag, " done cycle"}, done_at, 69);
    chk({tag, " final key"}, k3, 0);
  endtask

  initial begin
    Reset = 1'b1;
    v0 = 1'b0; p0 = 1'b0;
    v3 = 1'b0; p3 = 1'b0;
    repeat (2) tick;

    // Reset values
    chk("rst key0", k0, 1);
    chk("rst ready0", r0, 1);
    chk("rst busy0", b0, 0);
    chk("rst done0", d0, 0);
    chk("rst key3", k3, 1);
    chk("rst ready3", r3, 1);
    chk("rst busy3", b3, 0);
    chk("rst done3", d3, 0);
    Reset = 1'b0;
    tick;

    // Mid-cycle reset while a press is settling on the clean instance
    v0 = 1'b1; p0 = 1'b1;
    tick;
    v0 = 1'b0;
    chk("pre-reset key0", k0, 0);
    chk("pre-reset busy0", b0, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async rst key0", k0, 1);
    chk("async rst ready0", r0, 1);
    chk("async rst busy0", b0, 0);
    chk("async rst done0", d0, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("in rst key0", k0, 1);
      chk("in rst done0", d0, 0);
      chk("in rst busy0", b0, 0);
    end
    Reset = 1'b0;
    tick;

    // Press with Cmd_Valid held: second (same-level) press accepted when Ready rises
    v0 = 1'b1; p0 = 1'b1;
    tick;
    chk("press key0 T+1", k0, 0);
    chk("press busy0 T+1", b0, 1);
    chk("press ready0 T+1", r0, 0);
    for (int c = 2; c <= 14; c++) begin
      tick;
      chk("press key0 hold", k0, 0);
      chk("press done0", d0, 32'((c == 11) || (c == 13)));
      chk("press ready0", r0, 32'((c == 12) || (c == 14)));
      chk("press busy0", b0, 32'(!((c == 12) || (c == 14))));
      if (c == 13) v0 = 1'b0;
    end

    // Release on the clean instance
    v0 = 1'b1; p0 = 1'b0;
    tick;
    v0 = 1'b0;
    chk("release key0 T+1", k0, 1);
    for (int c = 2; c <= 12; c++) begin
      tick;
      chk("release key0 hold", k0, 1);
      chk("release done0", d0, 32'(c == 11));
      if (c == 12) chk("release ready0", r0, 1);
    end

    // Same-level release while Key is already high
    v0 = 1'b1; p0 = 1'b0;
    tick;
    v0 = 1'b0;
    chk("same done0 T+1", d0, 1);
    chk("same busy0 T+1", b0, 1);
    chk("same key0 T+1", k0, 1);
    chk("same ready0 T+1", r0, 0);
    tick;
    chk("same done0 T+2", d0, 0);
    chk("same busy0 T+2", b0, 0);
    chk("same ready0 T+2", r0, 1);
    chk("same key0 T+2", k0, 1);

    // Bouncing press aborted by reset after the third edge
    v3 = 1'b1; p3 = 1'b1;
    tick;
    v3 = 1'b0;
    chk("abort key3 c1", k3, 0);
    tick;
    chk("abort key3 c2", k3, 0);
    tick;
    chk("abort key3 c3", k3, 1);
    tick;
    chk("abort key3 c4", k3, 0);
    chk("abort busy3 c4", b3, 1);
    #2 Reset = 1'b1;
    #1;
    chk("abort async key3", k3, 1);
    chk("abort async busy3", b3, 0);
    chk("abort async ready3", r3, 1);
    chk("abort async done3", d3, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort in rst key3", k3, 1);
      chk("abort in rst done3", d3, 0);
    end
    Reset = 1'b0;
    tick;
    chk("abort post key3", k3, 1);
    chk("abort post done3", d3, 0);

    // Full press after reseed must reproduce the reference edge timing
    run_press3("bounce");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
